// File: rtl/cv32e40x_alu_b_clmul_stage.sv
// Two-register issue/capture pipeline wrapped around the combinational
// carry-less multiplier of the bitmanip ALU path.
//
// Stage 1 holds the operands, operator and tag of one CLMUL/CLMULH/CLMULR
// request and drives them straight into the external multiplier. Stage 2
// captures the multiplier result together with the tag and offers it to
// writeback. Both handshakes are valid/ready with full backpressure. An
// operation accepted on one clock edge is captured into stage 2 on the
// next edge when the pipeline is free to move.
//
// Stage 1 moves into stage 2 whenever stage 2 is empty or being drained in
// the same cycle, so a stream of back-to-back requests flows at one
// operation per cycle while writeback keeps up.
//
// flush_i kills everything in flight on the next edge and blocks intake for
// that cycle. Only the valid bits are cleared; the data registers keep
// their previous contents, which is harmless because nothing downstream
// qualifies them without a valid bit. Reset clears every register and wins
// over flush and both handshakes.

module cv32e40x_alu_b_clmul_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,

    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_op_a_i,
    input  logic [31:0]      in_op_b_i,
    input  logic [1:0]       in_operator_i,
    input  logic [TAG_W-1:0] in_tag_i,

    output logic [31:0]      clmul_op_a_o,
    output logic [31:0]      clmul_op_b_o,
    output logic [1:0]       clmul_operator_o,
    input  logic [31:0]      clmul_result_i,

    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_result_o,
    output logic [TAG_W-1:0] out_tag_o,

    output logic             busy_o
);

    // Stage 1: registered request feeding the multiplier
    logic             s1_valid;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2: captured result waiting for writeback
    logic             s2_valid;
    logic [31:0]      s2_result;
    logic [TAG_W-1:0] s2_tag;

    // Pipeline control
    logic             s2_free;
    logic             s1_adv;
    logic             accept;

    // Decide whether stage 1 moves into stage 2 and whether a new request
    // can enter; flush suppresses both so nothing slips past a kill.
    always_comb begin
        s2_free    = !s2_valid || out_ready_i;
        s1_adv     = s1_valid && s2_free && !flush_i;
        in_ready_o = !flush_i && (!s1_valid || s1_adv);
        accept     = in_valid_i && in_ready_o;
    end

    // Stage 1 register: load on accept, empty out when it advances with
    // nothing new behind it, and drop its content on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= 2'b00;
            s1_tag   <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_op_a_i;
            s1_b     <= in_op_b_i;
            s1_op    <= in_operator_i;
            s1_tag   <= in_tag_i;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 register: capture the multiplier result when stage 1 advances,
    // otherwise empty out once writeback has taken the current result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else if (flush_i) begin
            s2_valid  <= 1'b0;
        end else if (s1_adv) begin
            s2_valid  <= 1'b1;
            s2_result <= clmul_result_i;
            s2_tag    <= s1_tag;
        end else if (out_ready_i) begin
            s2_valid  <= 1'b0;
        end
    end

    // The multiplier sees stage 1 at all times; operator 11 is passed on
    // untouched and the multiplier treats it as CLMULH.
    assign clmul_op_a_o     = s1_a;
    assign clmul_op_b_o     = s1_b;
    assign clmul_operator_o = s1_op;

    // Writeback side comes straight from stage 2
    assign out_valid_o  = s2_valid;
    assign out_result_o = s2_result;
    assign out_tag_o    = s2_tag;

    assign busy_o = s1_valid || s2_valid;

endmodule

// File: tb/tb_cv32e40x_alu_b_clmul_stage.sv
// Testbench for cv32e40x_alu_b_clmul_stage.
// Supplies a behavioural carry-less multiplier on clmul_result_i, runs the
// directed scenarios and a random burst, and checks every delivered result
// against a queue of expected results built from the accepted requests.

module tb_cv32e40x_alu_b_clmul_stage;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_op_a_i;
    logic [31:0]      in_op_b_i;
    logic [1:0]       in_operator_i;
    logic [TAG_W-1:0] in_tag_i;
    logic [31:0]      clmul_op_a_o;
    logic [31:0]      clmul_op_b_o;
    logic [1:0]       clmul_operator_o;
    logic [31:0]      clmul_result_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_result_o;
    logic [TAG_W-1:0] out_tag_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    logic [31:0]      exp_result_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];

    cv32e40x_alu_b_clmul_stage #(.TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_op_a_i        (in_op_a_i),
        .in_op_b_i        (in_op_b_i),
        .in_operator_i    (in_operator_i),
        .in_tag_i         (in_tag_i),
        .clmul_op_a_o     (clmul_op_a_o),
        .clmul_op_b_o     (clmul_op_b_o),
        .clmul_operator_o (clmul_operator_o),
        .clmul_result_i   (clmul_result_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_result_o     (out_result_o),
        .out_tag_o        (out_tag_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    // Carry-less product by XOR-accumulating shifted copies of a, then
    // selecting the low word, bits 62:31 or the high word.
    function automatic logic [31:0] ref_clmul(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [1:0]  op);
        logic [63:0] prod;
        prod = 64'd0;
        for (int i = 0; i < 32; i++)
            if (b[i]) prod = prod ^ ({32'd0, a} << i);
        case (op)
            2'b00:   return prod[31:0];
            2'b10:   return prod[62:31];
            default: return prod[63:32];
        endcase
    endfunction

    // Multiplier model sitting behind the stage 1 outputs
    always_comb clmul_result_i = ref_clmul(clmul_op_a_o, clmul_op_b_o, clmul_operator_o);

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic [TAG_W-1:0] tag);
        in_valid_i    = v;
        in_op_a_i     = a;
        in_op_b_i     = b;
        in_operator_i = op;
        in_tag_i      = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs are stable mid-cycle, so look at the handshakes on
    // the falling edge and apply what the next rising edge will do.
    always @(negedge clk) begin
        if (rst) begin
            exp_result_q.delete();
            exp_tag_q.delete();
        end else begin
            if (out_valid_o && out_ready_i) begin
                if (exp_result_q.size() == 0) begin
                    checkOutput("unexpected_output", {31'd0, out_valid_o}, 32'd0);
                end else begin
                    checkOutput("sb_result", out_result_o, exp_result_q.pop_front());
                    checkOutput("sb_tag", {{(32-TAG_W){1'b0}}, out_tag_o},
                                {{(32-TAG_W){1'b0}}, exp_tag_q.pop_front()});
                end
            end
            if (flush_i) begin
                exp_result_q.delete();
                exp_tag_q.delete();
            end else if (in_valid_i && in_ready_o) begin
                exp_result_q.push_back(ref_clmul(in_op_a_i, in_op_b_i, in_operator_i));
                exp_tag_q.push_back(in_tag_i);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0]      ra [3];
        logic [31:0]      rb [3];
        logic [1:0]       rop[3];
        logic [31:0]      exp_b2b[3];
        logic [1:0]       b2b_op[3];

        rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        tick(); tick();

        // Reset state
        checkOutput("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("rst_out_result", out_result_o, 32'd0);
        checkOutput("rst_out_tag", {27'd0, out_tag_o}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        checkOutput("rst_clmul_a", clmul_op_a_o, 32'd0);
        checkOutput("rst_clmul_op", {30'd0, clmul_operator_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Single CLMUL 3 x 3 = 5
        out_ready_i = 1'b1;
        applyStimulus(1'b1, 32'h3, 32'h3, 2'b00, 5'd7);
        #1 checkOutput("t1_in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        #1;
        checkOutput("t1_s1_valid_only", {31'd0, out_valid_o}, 32'd0);
        checkOutput("t1_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("t1_clmul_a", clmul_op_a_o, 32'h3);
        tick();
        checkOutput("t1_out_valid", {31'd0, out_valid_o}, 32'd1);
        checkOutput("t1_result", out_result_o, 32'h5);
        checkOutput("t1_tag", {27'd0, out_tag_o}, 32'd7);
        tick();
        checkOutput("t1_drained", {31'd0, busy_o}, 32'd0);

        // Back-to-back all-ones with every operator kind
        b2b_op[0] = 2'b00; b2b_op[1] = 2'b01; b2b_op[2] = 2'b10;
        exp_b2b[0] = 32'h55555555; exp_b2b[1] = 32'h55555555; exp_b2b[2] = 32'hAAAAAAAA;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, b2b_op[i], 5'(10 + i));
            else       applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
            #1;
            checkOutput("b2b_in_ready", {31'd0, in_ready_o}, 32'd1);
            if (i >= 2) begin
                checkOutput("b2b_out_valid", {31'd0, out_valid_o}, 32'd1);
                checkOutput("b2b_result", out_result_o, exp_b2b[i-2]);
            end
            tick();
        end

        // Operator 11 behaves as CLMULH
        applyStimulus(1'b1, 32'h80000000, 32'h2, 2'b11, 5'd9);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        tick();
        checkOutput("op11_result", out_result_o, 32'h1);
        checkOutput("op11_tag", {27'd0, out_tag_o}, 32'd9);
        tick();

        // Backpressure: three requests with writeback stalled
        for (int i = 0; i < 3; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rop[i] = 2'($urandom_range(0, 3));
        end
        out_ready_i = 1'b0;
        applyStimulus(1'b1, ra[0], rb[0], rop[0], 5'd1);
        #1 checkOutput("bp_ready0", {31'd0, in_ready_o}, 32'd1);
        tick();
        applyStimulus(1'b1, ra[1], rb[1], rop[1], 5'd2);
        #1 checkOutput("bp_ready1", {31'd0, in_ready_o}, 32'd1);
        tick();
        applyStimulus(1'b1, ra[2], rb[2], rop[2], 5'd3);
        #1;
        checkOutput("bp_ready2_blocked", {31'd0, in_ready_o}, 32'd0);
        checkOutput("bp_hold_result", out_result_o, ref_clmul(ra[0], rb[0], rop[0]));
        tick();
        checkOutput("bp_still_blocked", {31'd0, in_ready_o}, 32'd0);
        checkOutput("bp_stable_result", out_result_o, ref_clmul(ra[0], rb[0], rop[0]));
        checkOutput("bp_stable_tag", {27'd0, out_tag_o}, 32'd1);
        out_ready_i = 1'b1;
        #1 checkOutput("bp_release_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        #1;
        checkOutput("bp_second", out_result_o, ref_clmul(ra[1], rb[1], rop[1]));
        checkOutput("bp_second_tag", {27'd0, out_tag_o}, 32'd2);
        tick();
        checkOutput("bp_third", out_result_o, ref_clmul(ra[2], rb[2], rop[2]));
        checkOutput("bp_third_tag", {27'd0, out_tag_o}, 32'd3);
        tick();
        checkOutput("bp_empty", {31'd0, busy_o}, 32'd0);

        // Flush a full pipeline while a request is presented
        out_ready_i = 1'b0;
        applyStimulus(1'b1, $urandom, $urandom, 2'b00, 5'd4);
        tick();
        applyStimulus(1'b1, $urandom, $urandom, 2'b01, 5'd5);
        tick();
        flush_i = 1'b1;
        applyStimulus(1'b1, 32'h1234, 32'h5678, 2'b10, 5'd6);
        #1 checkOutput("flush_in_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        #1;
        checkOutput("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("flush_busy", {31'd0, busy_o}, 32'd0);
        out_ready_i = 1'b1;
        applyStimulus(1'b1, 32'h7, 32'h5, 2'b00, 5'd8);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        tick();
        checkOutput("post_flush_result", out_result_o, 32'h1B);
        checkOutput("post_flush_tag", {27'd0, out_tag_o}, 32'd8);
        tick();

        // Reset in the middle of a stalled, full pipeline
        out_ready_i = 1'b0;
        applyStimulus(1'b1, 32'hDEADBEEF, 32'h3, 2'b00, 5'd11);
        tick();
        applyStimulus(1'b1, 32'hCAFEF00D, 32'h5, 2'b01, 5'd12);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        rst = 1'b1;
        tick();
        checkOutput("mrst_out_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("mrst_out_result", out_result_o, 32'd0);
        checkOutput("mrst_out_tag", {27'd0, out_tag_o}, 32'd0);
        checkOutput("mrst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("mrst_in_ready", {31'd0, in_ready_o}, 32'd1);
        checkOutput("mrst_clmul_b", clmul_op_b_o, 32'd0);
        rst = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mrst_no_stale", {31'd0, out_valid_o}, 32'd0);
        end

        // Random traffic with occasional flushes, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                          2'($urandom_range(0, 3)), 5'($urandom));
            out_ready_i = 1'($urandom_range(0, 2) != 0);
            flush_i     = 1'($urandom_range(0, 40) == 0);
            tick();
        end
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, '0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("drain_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("drain_queue_empty", exp_result_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
